// File: rtl/antares_cloz_arbiter.sv
// Shares one leading-ones/zeros counter between NUM_REQ requesters with a single-entry result buffer.
// Define ANTARES_CLOZ_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.

module antares_cloz (
  input  logic [31:0] data,
  output logic [5:0]  clz_result,
  output logic [5:0]  clo_result
);

  function automatic logic [5:0] count_lead(input logic [31:0] v, input logic ones);
    logic [5:0] n;
    logic       stop;
    n    = 6'd0;
    stop = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!stop && (v[i] == ones)) begin
        n = n + 6'd1;
      end else begin
        stop = 1'b1;
      end
    end
    return n;
  endfunction

  assign clz_result = count_lead(data, 1'b0);
  assign clo_result = count_lead(data, 1'b1);

endmodule

module antares_cloz_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_op,
  output logic [5:0]            rsp_result,
  input  logic                  rsp_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [31:0]        sel_data_s;
  logic               sel_op_s;
  logic               can_accept_s;
  logic               accept_s;
  logic [5:0]         clz_s;
  logic [5:0]         clo_s;
  int                 base_s;

`ifdef ANTARES_CLOZ_ARB_RR_EN
  logic [ID_W-1:0] ptr_r;

  // Pointer remembers the last accepted winner; stalled grants leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= ID_W'(NUM_REQ - 1);
    end else if (accept_s) begin
      ptr_r <= grant_idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign base_s = (int'(ptr_r) + 1) % NUM_REQ;
`else
  assign base_s = 0;
`endif

  // Search from base_s upward with wrap; first valid requester wins and drives the datapath mux.
  always_comb begin
    int   idx;
    logic found;
    grant_s     = '0;
    grant_idx_s = '0;
    sel_data_s  = 32'd0;
    sel_op_s    = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (base_s + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found        = 1'b1;
        grant_s[idx] = 1'b1;
        grant_idx_s  = ID_W'(idx);
        sel_data_s   = req_data[32*idx +: 32];
        sel_op_s     = req_op[idx];
      end else begin
        found = found;
      end
    end
  end

  assign can_accept_s = (state_r == EMPTY) | rsp_ready;
  assign req_ready    = grant_s & {NUM_REQ{can_accept_s}};
  assign accept_s     = |req_ready;
  assign rsp_valid    = (state_r == FULL);

  antares_cloz u_cloz (
    .data       (sel_data_s),
    .clz_result (clz_s),
    .clo_result (clo_s)
  );

  // Result buffer FSM: a drain and refill may happen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= EMPTY;
      rsp_id     <= '0;
      rsp_op     <= 1'b0;
      rsp_result <= 6'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r    <= FULL;
            rsp_id     <= grant_idx_s;
            rsp_op     <= sel_op_s;
            rsp_result <= sel_op_s ? clo_s : clz_s;
          end else begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (accept_s) begin
            state_r    <= FULL;
            rsp_id     <= grant_idx_s;
            rsp_op     <= sel_op_s;
            rsp_result <= sel_op_s ? clo_s : clz_s;
          end else if (rsp_ready) begin
            state_r <= EMPTY;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: doc/antares_cloz_arbiter.md
Name: antares_cloz_arbiter

Overview:
Shares one count-leading-ones/zeros datapath (an instance of antares_cloz) between NUM_REQ requesters. Typical requesters are the EX-stage CLO/CLZ instructions and a multi-cycle unit that needs normalization counts. The block arbitrates requests, registers one result in a single-entry output buffer, and returns it with the winning requester's ID over a valid/ready handshake.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of requester ID; must be >= clog2(NUM_REQ)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_op  input  NUM_REQ  per-requester operation: 0 = count leading zeros, 1 = count leading ones
req_data  input  32*NUM_REQ  per-requester operand; requester i uses bits [32*i+31:32*i]
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
rsp_valid  output  1  result buffer holds a valid result
rsp_id  output  ID_W  index of requester that owns the result
rsp_op  output  1  echoed operation of the held result
rsp_result  output  6  count, 0..32
rsp_ready  input  1  consumer accepts result this cycle

Behaviour:
- Reset (asynchronous, rst=1): rsp_valid=0, rsp_id=0, rsp_op=0, rsp_result=0, state=EMPTY, priority pointer=NUM_REQ-1 (requester 0 has highest priority first).
- Handshake: a transfer occurs on the rising edge where valid & ready are both 1. Requesters hold req_valid, req_op and req_data stable until accepted. The consumer samples rsp_* while rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready. A registered result can be drained and refilled in the same cycle.
- Grant: combinational, one-hot over the requesters with req_valid=1, chosen by the arbitration policy (see Optional Feature). req_ready[i] = grant[i] & can_accept. req_ready is 0 for all requesters when none is valid.
- Datapath: the granted operand and op are muxed into a single antares_cloz instance. The selected count (clo_result if op=1, else clz_result) is written to rsp_result on acceptance. rsp_id and rsp_op are written with it.
- Latency: exactly 1 cycle from acceptance to rsp_valid=1. Throughput: 1 result per cycle while rsp_ready=1.
- State machine:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on (accept & rsp_ready), which replaces the result.
  - FULL -> EMPTY on (rsp_ready & no accept).
  - FULL holds while rsp_ready=0. While held, rsp_* are stable and every req_ready is 0.
- rsp_valid = (state==FULL).
- Priority pointer updates only on an accepted grant, to the granted index. A stalled grant does not move it.
- Boundaries:
  - Operand 0x00000000: clz=32, clo=0.
  - Operand 0xFFFFFFFF: clo=32, clz=0.
  - Request withdrawn before acceptance is a protocol violation; behaviour is unspecified, but the block must not lock up.
  - rst asserted mid-transfer discards the held result immediately (rsp_valid drops asynchronously).
  - rsp_ready=1 while EMPTY is ignored.
- Indices >= NUM_REQ do not exist; the pointer wraps NUM_REQ-1 -> 0.

Optional Feature:
Macro ANTARES_CLOZ_ARB_RR_EN.
- Defined: round-robin. The search starts at pointer+1 modulo NUM_REQ, and the first valid requester wins.
- Undefined: fixed priority; lowest valid index wins. The pointer register is removed.
- In both modes the port list and handshake are identical.

Test Plan:
1. Reset, then requester 0 sends op=0, data=0x0000FFFF with rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_op=0, rsp_result=16.
2. Requester 1 sends op=1, data=0xFFFFFFFF, then op=0, data=0x00000000, back-to-back -> results 32 then 32, on consecutive cycles, rsp_id=1 both times.
3. RR_EN defined: both requesters valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1. Undefined: requester 0 wins every cycle and requester 1 starves.
4. Backpressure: fill buffer (op=1, data=0xF0000000 -> 4), hold rsp_ready=0 for 3 cycles -> rsp_result stays 4, all req_ready=0, pointer unchanged. Then rsp_ready=1 -> pending request accepted in that same cycle.
5. Assert rst while FULL -> rsp_valid=0 immediately, without waiting for a clock edge. After release, requester 0 has priority (RR mode).
6. Single-bit sweep: requester 0 sends op=0, data=1<<k for k=0..31 -> rsp_result=31-k for every k.
